// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI-slave (mode 0, MSB first) byte memory answering
// 23LC1024-style WRITE (0x02) and READ (0x03) commands with a 24-bit address
// and sequential auto-increment. All SPI pins are oversampled on wb_clk.
//
// Ports:
//   wb_clk    system clock, at least 8x the SCLK frequency
//   wb_rst    synchronous active-high reset
//   spi_cs_n  chip select, active low (asynchronous)
//   spi_sclk  SPI clock, idles low
//   spi_mosi  command/address/write data
//   spi_miso  read data, driven 0 outside READ
//   busy      high while a frame is being served
//   cmd_err   one-cycle pulse on an unsupported opcode
//
// Optional feature: define SPI_RESP_RDID_EN to answer RDID (0x9F) with the
// ID_WORD parameter followed by 0x00 bytes.
module spi_mem_responder #(
  parameter int unsigned MEM_BYTES = 1024
`ifdef SPI_RESP_RDID_EN
  , parameter logic [23:0] ID_WORD = 24'h5A_10_01
`endif
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic cmd_err
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
`ifdef SPI_RESP_RDID_EN
  localparam logic [7:0] OP_RDID  = 8'h9F;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WRITE, S_READ, S_IGNORE
  } state_t;

  state_t          state;
  logic [1:0]      cs_s, sclk_s, mosi_s;
  logic            sclk_prev, cs_prev;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [6:0]      sr;
  logic [6:0]      miso_sr;
  logic [AW-1:0]   addr;
  logic            is_write;
  logic            wr_pend;
  logic [7:0]      wr_data;
  logic            fetch_pend, load_pend;
  logic [7:0]      rd_data;
  logic [7:0]      mem [MEM_BYTES];

  logic            sclk_rise_c, sclk_fall_c, cs_fall_c, byte_done_c;
  logic [7:0]      byte_c, load_byte_c;

  // Two-stage synchronizers plus previous-sample taps for edge detection
  always_ff @(posedge wb_clk) begin
    cs_s      <= {cs_s[0], spi_cs_n};
    sclk_s    <= {sclk_s[0], spi_sclk};
    mosi_s    <= {mosi_s[0], spi_mosi};
    sclk_prev <= sclk_s[1];
  end

  assign sclk_rise_c = sclk_s[1] & ~sclk_prev;
  assign sclk_fall_c = ~sclk_s[1] & sclk_prev;
  assign cs_fall_c   = ~cs_s[1] & cs_prev;
  assign byte_c      = {sr, mosi_s[1]};
  assign byte_done_c = sclk_rise_c & (bit_cnt == 3'd7);

  // Byte storage: one write port, one registered read port; never reset
  always_ff @(posedge wb_clk) begin
    if (wr_pend) mem[addr] <= wr_data;
    rd_data <= mem[addr];
  end

`ifdef SPI_RESP_RDID_EN
  logic       rdid;
  logic [1:0] id_idx;

  // Source byte for the MISO loader: ID bytes in RDID mode, memory otherwise
  always_comb begin
    load_byte_c = rd_data;
    if (rdid) begin
      case (id_idx)
        2'd0:    load_byte_c = ID_WORD[23:16];
        2'd1:    load_byte_c = ID_WORD[15:8];
        2'd2:    load_byte_c = ID_WORD[7:0];
        default: load_byte_c = 8'h00;
      endcase
    end
  end
`else
  assign load_byte_c = rd_data;
`endif

  // Protocol FSM with registered outputs
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 2'd0;
      sr         <= 7'd0;
      miso_sr    <= 7'd0;
      addr       <= '0;
      is_write   <= 1'b0;
      wr_pend    <= 1'b0;
      wr_data    <= 8'h00;
      fetch_pend <= 1'b0;
      load_pend  <= 1'b0;
      cs_prev    <= 1'b0;  // a frame already in progress is never joined
      spi_miso   <= 1'b0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
`ifdef SPI_RESP_RDID_EN
      rdid       <= 1'b0;
      id_idx     <= 2'd0;
`endif
    end else begin
      cmd_err    <= 1'b0;
      wr_pend    <= 1'b0;
      fetch_pend <= 1'b0;
      load_pend  <= fetch_pend;  // rd_data is valid one cycle after the fetch
      cs_prev    <= cs_s[1];

      if (wr_pend) addr <= addr + AW'(1);

      if (sclk_rise_c && state != S_IDLE && state != S_IGNORE) begin
        sr      <= byte_c[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      case (state)
        S_IDLE: begin
          if (cs_fall_c) begin
            state    <= S_CMD;
            busy     <= 1'b1;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
        end
        S_CMD: begin
          if (byte_done_c) begin
`ifdef SPI_RESP_RDID_EN
            rdid <= 1'b0;
`endif
            case (byte_c)
              OP_WRITE: begin state <= S_ADDR; is_write <= 1'b1; end
              OP_READ:  begin state <= S_ADDR; is_write <= 1'b0; end
`ifdef SPI_RESP_RDID_EN
              OP_RDID: begin
                state      <= S_READ;
                rdid       <= 1'b1;
                id_idx     <= 2'd0;
                fetch_pend <= 1'b1;
              end
`endif
              default: begin state <= S_IGNORE; cmd_err <= 1'b1; end
            endcase
          end
        end
        S_ADDR: begin
          if (byte_done_c) begin
            // Upper address bits fall off the top of the register
            addr     <= AW'({addr, byte_c});
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd2) begin
              state      <= is_write ? S_WRITE : S_READ;
              fetch_pend <= ~is_write;
            end
          end
        end
        S_WRITE: begin
          if (byte_done_c) begin
            wr_pend <= 1'b1;
            wr_data <= byte_c;
          end
        end
        S_READ: begin
          if (byte_done_c) fetch_pend <= 1'b1;
          if (load_pend) begin
            spi_miso <= load_byte_c[7];
            miso_sr  <= load_byte_c[6:0];
`ifdef SPI_RESP_RDID_EN
            if (rdid) begin
              if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end else begin
              addr <= addr + AW'(1);
            end
`else
            addr <= addr + AW'(1);
`endif
          end else if (sclk_fall_c && bit_cnt != 3'd0) begin
            // The fall right after a byte boundary keeps bit 7 on the line
            spi_miso <= miso_sr[6];
            miso_sr  <= {miso_sr[5:0], 1'b0};
          end
        end
        S_IGNORE: ;
        default: state <= S_IDLE;
      endcase

      if (state != S_READ) begin
        spi_miso <= 1'b0;
        miso_sr  <= 7'd0;
      end

      if (cs_s[1]) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: an SPI master drives frames, a
// transaction-level byte-memory model predicts read data, and a per-cycle
// monitor checks busy, idle MISO and cmd_err pulse width.
module tb_spi_mem_responder;

  localparam int MEMB = 1024;
  localparam int HALF = 8;

  logic wb_clk = 1'b0;
  logic wb_rst, spi_cs_n, spi_sclk, spi_mosi;
  logic spi_miso, busy, cmd_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mm [MEMB];
  bit         known [MEMB];
  logic [7:0] wr_buf [64];
  logic [7:0] rd_buf [8];

  bit   mon_en = 1'b0;
  bit   miso_quiet = 1'b1;
  int   err_pulses = 0;
  logic [3:0] h = 4'hF;
  logic busy_m = 1'b0;
  logic cmd_err_d = 1'b0;

  spi_mem_responder #(.MEM_BYTES(MEMB)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // busy model: CS seen three cycles late; a frame is only joined on a CS fall
  always @(posedge wb_clk) begin
    h = {h[2:0], spi_cs_n};
    if (wb_rst)              busy_m = 1'b0;
    else if (h[2])           busy_m = 1'b0;
    else if (h[3] && !h[2])  busy_m = 1'b1;
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge wb_clk) begin
    if (mon_en) begin
      chk("busy", {7'd0, busy}, {7'd0, busy_m});
      if (miso_quiet) chk("miso_idle", {7'd0, spi_miso}, 8'h00);
      if (cmd_err) begin
        err_pulses++;
        chk("cmd_err_width", {7'd0, cmd_err_d}, 8'h00);
      end
      cmd_err_d = cmd_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, input bit open_rd,
                      output logic [7:0] rx);
    logic [7:0] t;
    t  = tx;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = t[7];
      t = t << 1;
      tick(HALF);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      if (open_rd && i == nbits - 1) miso_quiet = 1'b0;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    err_pulses = 0;
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic frame_end(input int exp_err);
    tick(6);
    spi_cs_n = 1'b1;
    tick(12);
    miso_quiet = 1'b1;
    chk("cmd_err_count", 8'(err_pulses), 8'(exp_err));
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, input bit open_rd);
    logic [7:0] d;
    xfer(op, 8, 1'b0, d);
    xfer(a[23:16], 8, 1'b0, d);
    xfer(a[15:8], 8, 1'b0, d);
    xfer(a[7:0], 8, open_rd, d);
  endtask

  task automatic mem_write(input logic [23:0] a, input int n, input int partial);
    logic [7:0] d;
    int idx;
    frame_start();
    send_hdr(8'h02, a, 1'b0);
    for (int i = 0; i < n; i++) begin
      xfer(wr_buf[i], 8, 1'b0, d);
      idx = (int'(a) + i) % MEMB;
      mm[idx] = wr_buf[i];
      known[idx] = 1'b1;
    end
    if (partial > 0) xfer(8'hE7, partial, 1'b0, d);
    frame_end(0);
  endtask

  task automatic mem_read(input logic [23:0] a, input int n, input string name);
    logic [7:0] rx;
    int idx;
    frame_start();
    send_hdr(8'h03, a, 1'b1);
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, 8, 1'b0, rx);
      rd_buf[i] = rx;
      idx = (int'(a) + i) % MEMB;
      if (known[idx]) chk(name, rx, mm[idx]);
    end
    frame_end(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic [31:0] exp_id;
    int exp_rdid_err;
    bit rdid_open;

    wb_rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    tick(6);
    mon_en = 1'b1;
    tick(4);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_miso", {7'd0, spi_miso}, 8'h00);
    chk("rst_cmd_err", {7'd0, cmd_err}, 8'h00);
    wb_rst = 1'b0;
    tick(4);

    // Known-zero regions used by later reads
    for (int i = 0; i < 64; i++) wr_buf[i] = 8'h00;
    mem_write(24'h000000, 64, 0);
    mem_write(24'h0003F0, 16, 0);

    // Sequential write then read back
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33; wr_buf[3] = 8'h44;
    mem_write(24'h000010, 4, 0);
    mem_read(24'h000010, 4, "rd_seq");
    chk("lit_seq0", rd_buf[0], 8'h11);
    chk("lit_seq1", rd_buf[1], 8'h22);
    chk("lit_seq2", rd_buf[2], 8'h33);
    chk("lit_seq3", rd_buf[3], 8'h44);

    // Address wrap at the top of memory
    wr_buf[0] = 8'hAA; wr_buf[1] = 8'hBB;
    mem_write(24'h0003FF, 2, 0);
    mem_read(24'h000000, 1, "rd_wrap_lo");
    chk("lit_wrap_lo", rd_buf[0], 8'hBB);
    mem_read(24'h0003FF, 2, "rd_wrap_hi");
    chk("lit_wrap_aa", rd_buf[0], 8'hAA);
    chk("lit_wrap_bb", rd_buf[1], 8'hBB);

    // Partial trailing byte must not be written
    wr_buf[0] = 8'h5C;
    mem_write(24'h000020, 1, 5);
    mem_read(24'h000020, 2, "rd_partial");
    chk("lit_part0", rd_buf[0], 8'h5C);
    chk("lit_part1", rd_buf[1], 8'h00);

    // Unsupported opcode: one cmd_err pulse, MISO silent, memory untouched
    frame_start();
    xfer(8'h07, 8, 1'b0, rx);
    xfer(8'h02, 8, 1'b0, rx);
    chk("ign_rx0", rx, 8'h00);
    xfer(8'hFF, 8, 1'b0, rx);
    chk("ign_rx1", rx, 8'h00);
    frame_end(1);
    mem_read(24'h00000E, 8, "rd_after_ign");

    // RDID
`ifdef SPI_RESP_RDID_EN
    exp_id = 32'h5A10_0100; exp_rdid_err = 0; rdid_open = 1'b1;
`else
    exp_id = 32'h0000_0000; exp_rdid_err = 1; rdid_open = 1'b0;
`endif
    frame_start();
    xfer(8'h9F, 8, rdid_open, rx);
    for (int i = 0; i < 4; i++) begin
      xfer(8'hFF, 8, 1'b0, rx);
      chk("rdid_byte", rx, exp_id[31 - 8*i -: 8]);
    end
    frame_end(exp_rdid_err);

    // Reset in the middle of a read data byte
    frame_start();
    send_hdr(8'h03, 24'h000010, 1'b1);
    xfer(8'hFF, 4, 1'b0, rx);
    chk("rst_partial_hi", rx, 8'h01);
    wb_rst = 1'b1;
    tick(1);
    miso_quiet = 1'b1;
    tick(2);
    wb_rst = 1'b0;
    tick(2);
    chk("rst_mid_busy", {7'd0, busy}, 8'h00);
    xfer(8'hFF, 8, 1'b0, rx);
    chk("rst_mid_rx", rx, 8'h00);
    frame_end(0);
    mem_read(24'h000010, 1, "rd_after_rst");
    chk("lit_after_rst", rd_buf[0], 8'h11);

    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

Synthesizable SPI-slave byte memory that answers the command stream produced by the Wishbone-to-SPI memory bridge. It gives the bridge a far-end target on the FPGA, for loopback bring-up and for self-checking benches without an external SRAM. All SPI inputs are oversampled on the system clock; there is no logic clocked by SCLK. Protocol is 23LC1024-style: mode 0, MSB first, 24-bit address, sequential auto-increment.

## Interface
- `MEM_BYTES`, default 1024: storage depth in bytes; power of two, 16..65536.
- `ID_WORD`, default 24'h5A_10_01: 3-byte ID returned by RDID (only when the macro is defined).
- `wb_clk`  in  1  system clock; must be ≥ 8× SCLK frequency.
- `wb_rst`  in  1  reset, synchronous and active-high.
- `spi_cs_n`  in  1  chip select, active low, asynchronous to `wb_clk`.
- `spi_sclk`  in  1  SPI clock, idles low (mode 0).
- `spi_mosi`  in  1  command/address/write data.
- `spi_miso`  out  1  read data.
- `busy`  out  1  high while a transaction is selected.
- `cmd_err`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- `spi_cs_n`, `spi_sclk` and `spi_mosi` each pass through a 2-FF synchronizer. Rising and falling SCLK edges are detected from the synchronized value and its previous sample.
- Rising edge: sample MOSI into an 8-bit shift register and increment a 3-bit bit counter. Falling edge: shift the MISO register.
- FSM states: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
  - IDLE → CMD when synchronized CS falls.
  - CMD → ADDR after 8 bits if opcode is 0x02 (WRITE) or 0x03 (READ).
  - CMD → READ if opcode is 0x9F and `SPI_RESP_RDID_EN` is defined.
  - CMD → IGNORE on any other opcode; pulse `cmd_err`.
  - ADDR → WRITE or READ after 24 bits. The address register keeps the low log2(MEM_BYTES) bits; higher bits are ignored.
  - Any state → IDLE when synchronized CS rises.
- WRITE: each completed byte (8th rising edge) is written to mem[addr] on the next cycle, then addr increments.
- READ: mem[addr] is fetched (1-cycle synchronous read) when the address phase completes and again after each 8th rising edge. The fetched byte loads the MISO shift register, and addr increments.
- Address wraps from MEM_BYTES-1 to 0 for both reads and writes.
- CS rising mid-byte: the partial write byte is discarded and memory is unchanged. Partial command or address is discarded.
- IGNORE: MISO held 0 and MOSI not stored until CS rises.
- `busy` = synchronized CS low (state ≠ IDLE).
- Memory contents are not cleared by reset.

## Timing
- Reset values: `spi_miso`=0, `busy`=0, `cmd_err`=0, state IDLE, bit counter 0, addr 0.
- Reset asserted mid-transaction: state goes to IDLE immediately. The FSM stays in IDLE until CS is seen high and then low again; it does not resynchronize mid-frame.
- Input-to-action latency: 3 `wb_clk` cycles from a pin edge (2 sync stages plus edge detect).
- MISO: bit 7 of the first read byte is driven no later than 3 cycles after the last address bit's rising edge is detected. This is before the next SCLK falling edge given the ≥8× ratio. Each subsequent bit changes 3 cycles after a falling SCLK edge.
- Master requirement: SCLK high and low phases ≥ 4 `wb_clk` cycles; CS setup/hold to SCLK ≥ 4 `wb_clk` cycles.
- `spi_miso` outside READ: driven 0, never tri-stated. Pad-level tri-state belongs to the top level, using `busy`.

## Configuration
- `SPI_RESP_RDID_EN` defined: opcode 0x9F enters READ with source `ID_WORD`. Bytes are sent MSB-first, then 0x00 repeats until CS rises. No address phase. `cmd_err` does not pulse for 0x9F.
- Not defined: 0x9F is treated as unsupported (IGNORE, `cmd_err` pulses), and the ID logic is absent.

## Test plan
- WRITE 0x02, addr 0x000010, data 0x11 0x22 0x33 0x44; then READ 0x03 of 0x000010 for 4 bytes -> MISO returns 0x11 0x22 0x33 0x44; `busy` high only while CS is low.
- MEM_BYTES=1024: WRITE 0xAA 0xBB at addr 0x0003FF -> READ at 0x000000 returns 0xBB (wrap), and READ at 0x0003FF returns 0xAA.
- WRITE to 0x000020 with 0x5C, then CS rises after 5 bits of a second byte -> READ at 0x000021 returns the prior content (0x00 after an initial fill of zeros).
- Opcode 0x07 -> `cmd_err` pulses exactly 1 cycle, MISO stays 0 for 16 further SCLKs, and memory is unchanged.
- With `SPI_RESP_RDID_EN`: 0x9F followed by 4 bytes clocked -> 0x5A 0x10 0x01 0x00. Without the macro: `cmd_err` pulses and MISO reads 0x00 0x00 0x00 0x00.
- `wb_rst` pulsed during a READ data byte, then a new CS frame READ at 0x000010 -> returns the previously written 0x11 (memory retained, FSM restarted).
